// File: rtl/rsc_dec_paddr_gen_if.sv
// Handshake and address bus of the multi-lane RSC decoder address generator.
// master drives the controls and configuration, slave is the generator.
interface rsc_dec_paddr_gen_if #(
  parameter int pW      = 13,
  parameter int pN_LANE = 4
);
  logic                          istart;
  logic                          iclear;
  logic                          ienable;
  logic                          ipmode;
  logic [pW-1:0]                 iN;
  logic [pW-1:0]                 iWlen;
  logic [pW-1:0]                 iP0;
  logic [pW-1:0]                 iP0comp;
  logic [pW-1:0]                 iP0L;
  logic [pW-1:0]                 iP0Lend;
  logic [3:0][pW-1:0]            iQ;
  logic                          iPdvbinv;
  logic [pN_LANE-1:0][pW-1:0]    osaddr;
  logic [pN_LANE-1:0][pW-1:0]    opaddr;
  logic [pN_LANE-1:0]            obitinv;
  logic                          oval;
  logic [pN_LANE-1:0]            olane_val;
  logic                          olast;
  logic                          odone;

  modport master (
    output istart, iclear, ienable, ipmode, iN, iWlen, iP0, iP0comp,
           iP0L, iP0Lend, iQ, iPdvbinv,
    input  osaddr, opaddr, obitinv, oval, olane_val, olast, odone
  );

  modport slave (
    input  istart, iclear, ienable, ipmode, iN, iWlen, iP0, iP0comp,
           iP0L, iP0Lend, iQ, iPdvbinv,
    output osaddr, opaddr, obitinv, oval, olane_val, olast, odone
  );
endinterface

// File: rtl/rsc_dec_paddr_gen.sv
// Window-parallel natural/permuted address generator for MAP decoding lanes.
// Optional macro RSC_DEC_PADDR_TAIL_EN: N may be shorter than lanes*L; lanes past N are masked.
module rsc_dec_paddr_gen #(
  parameter int pW      = 13,
  parameter int pN_LANE = 4,
  parameter bit pB_nF   = 1'b0
) (
  input logic               iclk,
  input logic               ireset,
  input logic               iclkena,
  rsc_dec_paddr_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, LOAD, RUN} state_t;

  localparam int CW = (pN_LANE > 1) ? $clog2(pN_LANE) : 1;
  localparam logic [pW-1:0] ONE = pW'(1);

  // (a + b) mod n with a, b < n: one conditional subtract chosen by the borrow
  function automatic logic [pW-1:0] mod_add(input logic [pW-1:0] a,
                                            input logic [pW-1:0] b,
                                            input logic [pW-1:0] n);
    logic [pW:0]   s;
    logic [pW+1:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, s} - {2'b00, n};
    mod_add = d[pW+1] ? s[pW-1:0] : d[pW-1:0];
  endfunction

  function automatic logic [pN_LANE-1:0] bit_inv(input logic [pN_LANE-1:0][pW-1:0] j,
                                                 input logic                        inv);
    for (int k = 0; k < pN_LANE; k++) bit_inv[k] = inv ? ~j[k][0] : j[k][0];
  endfunction

  state_t                     state;
  logic [CW-1:0]              init_cnt;
  logic                       pmode;
  logic [pW-1:0]              chain_acc;
  logic [pW-1:0]              chain_j;
  logic [pW-1:0]              step;
  logic [pN_LANE-1:0][pW-1:0] acc;
  logic [pN_LANE-1:0][pW-1:0] j_r;
  logic [pN_LANE-1:0][pW-1:0] saddr_r;
  logic [pN_LANE-1:0]         bitinv_r;
  logic                       val_r;
  logic                       last_r;
  logic                       done_r;

  logic [pN_LANE-1:0][pW-1:0] j_nx;
  logic [pN_LANE-1:0][pW-1:0] acc_nx;
  logic [pN_LANE-1:0][pW-1:0] saddr_ld;
  logic [pN_LANE-1:0][pW-1:0] saddr_nx;
  logic [pW-1:0]              q_ld;
  logic [pW-1:0]              q_nx;
  logic [pW-1:0]              step_inc;
  logic                       load_ev;
  logic                       adv_ev;

  // All lanes share j mod 4 because L is a multiple of 4, so lane 0 picks Q
  always_comb begin
    step_inc = step + ONE;
    j_nx     = '0;
    acc_nx   = '0;
    saddr_ld = '0;
    saddr_nx = '0;
    for (int k = 0; k < pN_LANE; k++) begin
      j_nx[k]   = pB_nF ? (j_r[k] - ONE) : (j_r[k] + ONE);
      acc_nx[k] = mod_add(acc[k], pB_nF ? bus.iP0comp : bus.iP0, bus.iN);
    end
    q_ld = bus.iQ[j_r[0][1:0]];
    q_nx = bus.iQ[j_nx[0][1:0]];
    for (int k = 0; k < pN_LANE; k++) begin
      saddr_ld[k] = pmode ? mod_add(acc[k], q_ld, bus.iN) : j_r[k];
      saddr_nx[k] = pmode ? mod_add(acc_nx[k], q_nx, bus.iN) : j_nx[k];
    end
  end

  assign load_ev = iclkena && !bus.iclear && (state == LOAD);
  assign adv_ev  = iclkena && !bus.iclear && (state == RUN) && bus.ienable && !last_r;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state    <= IDLE;
      init_cnt <= '0;
      pmode    <= 1'b0;
      j_r      <= '0;
      saddr_r  <= '0;
      bitinv_r <= '0;
      val_r    <= 1'b0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (iclkena) begin
      done_r <= 1'b0;
      if (bus.iclear) begin
        state  <= IDLE;
        val_r  <= 1'b0;
        last_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.istart) begin
              state     <= INIT;
              pmode     <= bus.ipmode;
              init_cnt  <= '0;
              chain_acc <= pB_nF ? bus.iP0Lend : '0;
              chain_j   <= pB_nF ? (bus.iWlen - ONE) : '0;
            end
          end
          // Lane bases shift in from the top; after pN_LANE clocks lane 0 holds the first
          INIT: begin
            for (int k = 0; k < pN_LANE - 1; k++) begin
              acc[k] <= acc[k+1];
              j_r[k] <= j_r[k+1];
            end
            acc[pN_LANE-1] <= chain_acc;
            j_r[pN_LANE-1] <= chain_j;
            chain_acc      <= mod_add(chain_acc, bus.iP0L, bus.iN);
            chain_j        <= chain_j + bus.iWlen;
            init_cnt       <= init_cnt + CW'(1);
            if (init_cnt == CW'(pN_LANE - 1)) state <= LOAD;
          end
          LOAD: begin
            saddr_r  <= saddr_ld;
            bitinv_r <= bit_inv(j_r, bus.iPdvbinv);
            step     <= '0;
            last_r   <= 1'b0;
            val_r    <= 1'b1;
            state    <= RUN;
          end
          RUN: begin
            if (bus.ienable) begin
              if (last_r) begin
                state  <= IDLE;
                val_r  <= 1'b0;
                last_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                j_r      <= j_nx;
                acc      <= acc_nx;
                saddr_r  <= saddr_nx;
                bitinv_r <= bit_inv(j_nx, bus.iPdvbinv);
                step     <= step_inc;
                last_r   <= (step_inc == (bus.iWlen - ONE));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RSC_DEC_PADDR_TAIL_EN
  logic [pN_LANE-1:0] lane_val_r;

  function automatic logic [pN_LANE-1:0] lane_ok(input logic [pN_LANE-1:0][pW-1:0] j,
                                                 input logic [pW-1:0]              n);
    for (int k = 0; k < pN_LANE; k++) lane_ok[k] = (j[k] < n);
  endfunction

  always_ff @(posedge iclk) begin
    if (ireset)       lane_val_r <= '0;
    else if (load_ev) lane_val_r <= lane_ok(j_r, bus.iN);
    else if (adv_ev)  lane_val_r <= lane_ok(j_nx, bus.iN);
  end

  assign bus.olane_val = lane_val_r;
`else
  assign bus.olane_val = '1;
`endif

  assign bus.osaddr  = saddr_r;
  assign bus.opaddr  = j_r;
  assign bus.obitinv = bitinv_r;
  assign bus.oval    = val_r;
  assign bus.olast   = last_r;
  assign bus.odone   = done_r;

endmodule

// File: doc/rsc_dec_paddr_gen.md
Name: rsc_dec_paddr_gen

Overview:
- Multi-lane successor to the single-engine RSC decoder address generator, for window-parallel MAP decoding.
- The block is split into pN_LANE equal windows of iWlen duobits. Each lane gets its own natural address j and permuted address pi(j) = (P0*j + Q[j mod 4]) mod N each step.
- Direction is set by pB_nF: forward recursion walks each window upward, backward recursion walks it downward.
- Sits between the decoder control FSM and the per-lane extrinsic/systematic RAM address ports.

Parameters:
pW, 13, address/arithmetic width; N < 2^pW.
pN_LANE, 4, number of parallel windows (lanes), 1..16.
pB_nF, 0, 0 = forward (j increments), 1 = backward (j decrements).

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
iclkena  in  1  clock enable; all state frozen when low
istart  in  1  start pulse, accepted only in IDLE
iclear  in  1  abort; any state -> IDLE next enabled clock
ienable  in  1  consume current step (advance)
ipmode  in  1  1 = permuted osaddr, 0 = osaddr equals opaddr; latched at istart
iN  in  pW  block size in duobits
iWlen  in  pW  window length L, multiple of 4, >= 4
iP0  in  pW  P0 mod N
iP0comp  in  pW  (N - P0) mod N
iP0L  in  pW  (P0*L) mod N, lane-to-lane offset
iP0Lend  in  pW  (P0*(L-1)) mod N, backward start offset of lane 0
iQ  in  4 x pW  {Q0..Q3}, each < N
iPdvbinv  in  1  duobit swap polarity
osaddr  out  pN_LANE x pW  systematic (permuted) address per lane
opaddr  out  pN_LANE x pW  natural address j per lane
obitinv  out  pN_LANE  iPdvbinv ? !j[0] : j[0]
oval  out  1  addresses valid
olane_val  out  pN_LANE  per-lane validity (all-ones without optional feature)
olast  out  1  current step is the last of the window
odone  out  1  one-cycle pulse after the last step is consumed

Behaviour:
- Reset: FSM in IDLE; all outputs 0.
- FSM: IDLE -(istart)-> INIT -(pN_LANE clocks)-> RUN -(ienable & olast)-> IDLE, with odone=1 for one clock. iclear has priority over everything, including istart and ienable.
- Reset or iclear mid-operation: oval=0 next clock; no odone pulse.
- INIT:
  - Sequential modular chain: acc[0] = 0 (fwd) or iP0Lend (bwd); acc[k] = acc[k-1] + iP0L mod N.
  - Lane base j0[k] = k*L; j starts at j0 (fwd) or j0+L-1 (bwd).
  - ipmode is latched at istart.
  - Take exactly pN_LANE enabled clocks.
- RUN:
  - oval=1; outputs are registered and held while ienable=0.
  - On ienable: next clock presents step s+1.
  - Fwd: j+1, acc = acc + iP0 mod N. Bwd: j-1, acc = acc + iP0comp mod N.
  - osaddr = acc + Q[j mod 4] mod N.
- Step count: step counter 0..L-1; olast=1 when counter = L-1.
- Mod add: (pW+1)-bit sum, subtract N, select by borrow. Inputs must be < N, so no multi-wrap.
- Latency: istart sampled at edge 0 -> first oval=1 after edge pN_LANE+1.
- Lane phase: because L is a multiple of 4, all lanes share j mod 4; a single Q-select is shared.
- Ignored inputs: istart in INIT or RUN is ignored; ienable outside RUN is ignored.

Optional Feature:
- Macro: RSC_DEC_PADDR_TAIL_EN.
- Defined: N need not equal pN_LANE*L. olane_val[k] = (j[k] <= N-1); lanes with j >= N still step with mod-N arithmetic, but are masked. Typically this affects the last lane, which is masked at the end of its window (fwd) or at the start (bwd).
- Not defined: N must equal pN_LANE*L; olane_val is constant all-ones.

Test Plan:
- Fwd, N=48, L=12, 4 lanes, P0=5, Q={1,3,7,11}, ipmode=1, istart -> first oval: opaddr {0,12,24,36}, osaddr {1,13,25,37}; next ienable -> lane0 j=1, osaddr 8; olast at step 11; odone follows.
- Bwd, same constants (iP0Lend=7, iP0comp=43) -> first step: lane0 j=11 osaddr 18, lane1 j=23 osaddr 30.
- ipmode=0 -> osaddr == opaddr every step. iPdvbinv=1 -> obitinv = !j[0].
- ienable toggled 1/0 randomly -> outputs held while low; total of 12 accepted steps; odone once.
- iclear asserted at RUN step 5 -> oval=0 next clock, no odone; a new istart restarts cleanly. ireset with istart high -> stays IDLE.
- TAIL_EN, N=44, L=12 fwd -> olane_val[3]=0 for steps 8..11, other lanes 1. Without the macro -> olane_val all-ones.
